// File: rtl/reduce_combine_pkg.sv
// Shared definitions for the short-reduction receive path.
// Holds flit field positions and widths, reduction op codes and
// reduction-table entry states. The packet-build side reuses the same layout.
package reduce_combine_pkg;

    // Field positions inside a 76-bit children-tagged input flit. The low
    // 73 bits share their layout with the outgoing network flit.
    localparam int unsigned PayloadPos  = 0;
    localparam int unsigned OpPos       = 32;
    localparam int unsigned OpWidth     = 4;
    localparam int unsigned AlgPos      = 36;
    localparam int unsigned AlgWidth    = 2;
    localparam int unsigned TagPos      = 38;
    localparam int unsigned TagWidth    = 8;
    localparam int unsigned CtxPos      = 46;
    localparam int unsigned CtxWidth    = 8;
    localparam int unsigned SrcPos      = 54;
    localparam int unsigned DstPos      = 63;
    localparam int unsigned AddrWidth   = 9;   // {z, y, x}, 3 bits each
    localparam int unsigned ValidBitPos = 72;
    localparam int unsigned ChildrenPos = 73;

    // Reduction op codes; any other code folds as a sum.
    localparam logic [OpWidth-1:0] OpSum = 4'd0;
    localparam logic [OpWidth-1:0] OpMax = 4'd1;
    localparam logic [OpWidth-1:0] OpMin = 4'd2;
    localparam logic [OpWidth-1:0] OpAnd = 4'd3;
    localparam logic [OpWidth-1:0] OpOr  = 4'd4;
    localparam logic [OpWidth-1:0] OpXor = 4'd5;

    typedef enum logic [1:0] {
        EntFree  = 2'd0,
        EntAccum = 2'd1,
        EntDone  = 2'd2
    } ent_state_e;

endpackage

// File: rtl/reduce_combine_alu.sv
// reduce_alu: combinational fold of one contribution into an accumulator.
// Ports:
//   i_op     reduction op code
//   i_a      current accumulator
//   i_b      incoming contribution
//   o_result folded value (MAX/MIN compare as signed)
module reduce_alu
    import reduce_combine_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [OpWidth-1:0] i_op,
    input  logic [Width-1:0]   i_a,
    input  logic [Width-1:0]   i_b,
    output logic [Width-1:0]   o_result
);

    always_comb begin
        o_result = i_a + i_b;
        case (i_op)
            OpMax:   o_result = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
            OpMin:   o_result = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            OpAnd:   o_result = i_a & i_b;
            OpOr:    o_result = i_a | i_b;
            OpXor:   o_result = i_a ^ i_b;
            default: o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/reduce_combine.sv
// reduce_combine: receive end of the short-reduction path.
// Folds contributions per {contextId, tag} in a small table and emits one
// reduced flit per completed operation towards the parent.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   packetIn   {children, valid, dst, src, ctx, tag, algtype, op, payload}
//   in_ready   input accepted when packetIn[72] && in_ready
//   packetOut  registered reduced flit, bit 72 is valid
//   out_ready  downstream accepts packetOut when valid && out_ready
module reduce_combine
    import reduce_combine_pkg::*;
#(
    parameter int unsigned FlitWidth     = 73,
    parameter int unsigned ChildrenWidth = 3,
    parameter int unsigned TableSize     = 4,
    parameter int unsigned PayloadWidth  = 32,
    parameter logic [2:0]  rank_z        = 3'b0,
    parameter logic [2:0]  rank_y        = 3'b0,
    parameter logic [2:0]  rank_x        = 3'b0,
    parameter logic [2:0]  parent_z      = 3'b0,
    parameter logic [2:0]  parent_y      = 3'b0,
    parameter logic [2:0]  parent_x      = 3'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FlitWidth+ChildrenWidth-1:0] packetIn,
    output logic                               in_ready,
    output logic [FlitWidth-1:0]               packetOut,
    input  logic                               out_ready
);

    localparam int unsigned IdxWidth = (TableSize > 1) ? $clog2(TableSize) : 1;

    ent_state_e              r_state [TableSize];
    logic [CtxWidth-1:0]     r_ctx   [TableSize];
    logic [TagWidth-1:0]     r_tag   [TableSize];
    logic [AlgWidth-1:0]     r_alg   [TableSize];
    logic [OpWidth-1:0]      r_op    [TableSize];
    logic [PayloadWidth-1:0] r_acc   [TableSize];
    logic [ChildrenWidth-1:0] r_need [TableSize];
    logic [ChildrenWidth-1:0] r_got  [TableSize];
    logic [FlitWidth-1:0]    r_out;

    logic                     w_in_valid;
    logic [CtxWidth-1:0]      w_in_ctx;
    logic [TagWidth-1:0]      w_in_tag;
    logic [AlgWidth-1:0]      w_in_alg;
    logic [OpWidth-1:0]       w_in_op;
    logic [PayloadWidth-1:0]  w_in_payload;
    logic [ChildrenWidth-1:0] w_in_children;
    logic                     w_unused_route;

    assign w_in_valid     = packetIn[ValidBitPos];
    assign w_in_ctx       = packetIn[CtxPos +: CtxWidth];
    assign w_in_tag       = packetIn[TagPos +: TagWidth];
    assign w_in_alg       = packetIn[AlgPos +: AlgWidth];
    assign w_in_op        = packetIn[OpPos +: OpWidth];
    assign w_in_payload   = packetIn[PayloadPos +: PayloadWidth];
    assign w_in_children  = packetIn[ChildrenPos +: ChildrenWidth];
    // Incoming dst/src are replaced by parent/rank on the way out.
    assign w_unused_route = ^packetIn[SrcPos +: 2*AddrWidth];

    logic                w_hit, w_free_any, w_done_any;
    logic [IdxWidth-1:0] w_hit_idx, w_free_idx, w_done_idx;

    // Descending scan so the lowest matching index wins each search.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_done_any = 1'b0;
        w_done_idx = '0;
        for (int i = int'(TableSize) - 1; i >= 0; i--) begin
            if (r_state[i] != EntFree && r_ctx[i] == w_in_ctx && r_tag[i] == w_in_tag) begin
                w_hit     = 1'b1;
                w_hit_idx = IdxWidth'(i);
            end
            if (r_state[i] == EntFree) begin
                w_free_any = 1'b1;
                w_free_idx = IdxWidth'(i);
            end
            if (r_state[i] == EntDone) begin
                w_done_any = 1'b1;
                w_done_idx = IdxWidth'(i);
            end
        end
    end

    // A hit on a finished entry stalls so late data never folds into a result.
    always_comb begin
        in_ready = 1'b1;
        if (w_in_valid) begin
            in_ready = w_hit ? (r_state[w_hit_idx] == EntAccum) : w_free_any;
        end
    end

    logic [PayloadWidth-1:0]  w_alu_result;
    logic                     w_accept, w_complete, w_out_load, w_bypass;
    logic [ChildrenWidth-1:0] w_got_inc;
    logic [IdxWidth-1:0]      w_slot;
    ent_state_e               w_next_state;
    logic [PayloadWidth-1:0]  w_res_acc;
    logic [OpWidth-1:0]       w_res_op;
    logic [AlgWidth-1:0]      w_res_alg;
    logic [FlitWidth-1:0]     w_done_flit, w_bypass_flit;

    reduce_alu #(
        .Width (PayloadWidth)
    ) u_alu (
        .i_op     (r_op[w_hit_idx]),
        .i_a      (r_acc[w_hit_idx]),
        .i_b      (w_in_payload),
        .o_result (w_alu_result)
    );

    assign w_accept   = w_in_valid & in_ready;
    assign w_got_inc  = r_got[w_hit_idx] + ChildrenWidth'(1);
    assign w_complete = w_accept && (w_hit ? (w_got_inc == r_need[w_hit_idx])
                                           : (w_in_children <= ChildrenWidth'(1)));
    assign w_res_acc  = w_hit ? w_alu_result : w_in_payload;
    assign w_res_op   = w_hit ? r_op[w_hit_idx] : w_in_op;
    assign w_res_alg  = w_hit ? r_alg[w_hit_idx] : w_in_alg;
    assign w_slot     = w_hit ? w_hit_idx : w_free_idx;

    // A completion goes straight to the output register when nothing older
    // is waiting, giving one-cycle latency and full throughput.
    assign w_out_load   = !r_out[ValidBitPos] || out_ready;
    assign w_bypass     = w_out_load && !w_done_any && w_complete;
    assign w_next_state = w_bypass ? EntFree : (w_complete ? EntDone : EntAccum);

    assign w_done_flit = {1'b1, parent_z, parent_y, parent_x, rank_z, rank_y, rank_x,
                          r_ctx[w_done_idx], r_tag[w_done_idx], r_alg[w_done_idx],
                          r_op[w_done_idx], r_acc[w_done_idx]};
    assign w_bypass_flit = {1'b1, parent_z, parent_y, parent_x, rank_z, rank_y, rank_x,
                            w_in_ctx, w_in_tag, w_res_alg, w_res_op, w_res_acc};

    // Drained and accepted slots never coincide: accepts only touch ACCUM or
    // FREE entries, draining only touches a DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(TableSize); i++) begin
                r_state[i] <= EntFree;
                r_ctx[i]   <= '0;
                r_tag[i]   <= '0;
                r_alg[i]   <= '0;
                r_op[i]    <= '0;
                r_acc[i]   <= '0;
                r_need[i]  <= '0;
                r_got[i]   <= '0;
            end
            r_out <= '0;
        end else begin
            if (w_out_load) begin
                if (w_done_any) begin
                    r_out               <= w_done_flit;
                    r_state[w_done_idx] <= EntFree;
                end else if (w_bypass) begin
                    r_out <= w_bypass_flit;
                end else begin
                    r_out <= '0;
                end
            end
            if (w_accept) begin
                r_state[w_slot] <= w_next_state;
                r_acc[w_slot]   <= w_res_acc;
                r_got[w_slot]   <= w_hit ? w_got_inc : ChildrenWidth'(1);
                if (!w_hit) begin
                    r_ctx[w_slot]  <= w_in_ctx;
                    r_tag[w_slot]  <= w_in_tag;
                    r_alg[w_slot]  <= w_in_alg;
                    r_op[w_slot]   <= w_in_op;
                    r_need[w_slot] <= w_in_children;
                end
            end
        end
    end

    assign packetOut = r_out;

endmodule

// File: tb/tb_reduce_combine.sv
module tb_reduce_combine;
    import reduce_combine_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [75:0] packetIn;
    logic        in_ready;
    logic [72:0] packetOut;
    logic        out_ready;

    always #5 clk = ~clk;

    reduce_combine #(
        .rank_z   (3'd1),
        .rank_y   (3'd2),
        .rank_x   (3'd3),
        .parent_z (3'd4),
        .parent_y (3'd5),
        .parent_x (3'd6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .packetIn  (packetIn),
        .in_ready  (in_ready),
        .packetOut (packetOut),
        .out_ready (out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0]  ctx;
        logic [7:0]  tag;
        logic [1:0]  alg;
        logic [3:0]  op;
        logic [31:0] acc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [75:0] mk(input logic [2:0] ch, input logic [7:0] ctx,
                                       input logic [7:0] tag, input logic [1:0] alg,
                                       input logic [3:0] op, input logic [31:0] pl);
        return {ch, 1'b1, 9'($urandom), 9'($urandom), ctx, tag, alg, op, pl};
    endfunction

    function automatic logic [72:0] ex(input logic [7:0] ctx, input logic [7:0] tag,
                                       input logic [1:0] alg, input logic [3:0] op,
                                       input logic [31:0] acc);
        return {1'b1, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, ctx, tag, alg, op, acc};
    endfunction

    // Reference fold written from the op-code table.
    function automatic logic [31:0] fold(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        int sa, sb_v;
        sa   = a;
        sb_v = b;
        case (op)
            4'd1:    return (sa > sb_v) ? a : b;
            4'd2:    return (sa < sb_v) ? a : b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [75:0] obs, input logic [75:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
        end
    endtask

    // Present a flit from posedge+1 until accepted; returns at posedge+1 after.
    task automatic send(input logic [75:0] f, input bit rnd);
        bit got;
        got = 1'b0;
        packetIn = f;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        chk("send_accept", 76'(got), 76'(1));
        @(posedge clk);
        #1;
        packetIn = '0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Random-phase scoreboard: every handshaken output must match one
    // completed operation by {ctx, tag}.
    always @(negedge clk) begin
        int idx;
        if (mon_en && packetOut[72] && out_ready) begin
            idx = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (idx < 0 && sb[j].ctx == packetOut[53:46] && sb[j].tag == packetOut[45:38])
                    idx = j;
            end
            chk("rand_known_key", 76'(idx >= 0), 76'(1));
            if (idx >= 0) begin
                chk("rand_out", 76'(packetOut),
                    76'(ex(sb[idx].ctx, sb[idx].tag, sb[idx].alg, sb[idx].op, sb[idx].acc)));
                sb.delete(idx);
            end
        end
    end

    logic [75:0] f;
    logic [2:0]  ch   [4];
    int          need [4];
    int          cnt  [4];
    logic [31:0] racc [4];
    logic [3:0]  rop  [4];
    logic [1:0]  ralg [4];
    logic [7:0]  rctx [4];
    int          order[$];
    logic [31:0] pl;
    logic [3:0]  op_send;

    initial begin
        rst       = 1'b0;
        packetIn  = '0;
        out_ready = 1'b1;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out", 76'(packetOut), 76'(0));
        chk("rst_ready", 76'(in_ready), 76'(1));

        // Reset mid-operation with two entries accumulating.
        send(mk(3'd3, 8'd1, 8'd1, 2'd0, 4'd0, 32'd100), 0);
        send(mk(3'd2, 8'd2, 8'd2, 2'd0, 4'd0, 32'd200), 0);
        chk("t1_no_out", 76'(packetOut[72]), 76'(0));
        packetIn = mk(3'd3, 8'd1, 8'd1, 2'd0, 4'd0, 32'd50);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_out", 76'(packetOut), 76'(0));
        chk("t1_rst_ready", 76'(in_ready), 76'(1));
        packetIn = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        send(mk(3'd2, 8'd1, 8'd1, 2'd1, 4'd0, 32'd100), 0);
        send(mk(3'd2, 8'd1, 8'd1, 2'd1, 4'd0, 32'd1), 0);
        chk("t1_fresh", 76'(packetOut), 76'(ex(8'd1, 8'd1, 2'd1, 4'd0, 32'd101)));

        // SUM over three children, wrapping modulo 2^32.
        send(mk(3'd3, 8'd0, 8'd1, 2'd2, 4'd0, 32'd5), 0);
        chk("t2_partial1", 76'(packetOut[72]), 76'(0));
        send(mk(3'd3, 8'd0, 8'd1, 2'd2, 4'd0, 32'd7), 0);
        chk("t2_partial2", 76'(packetOut[72]), 76'(0));
        send(mk(3'd3, 8'd0, 8'd1, 2'd2, 4'd0, 32'hFFFF_FFFE), 0);
        chk("t2_sum", 76'(packetOut), 76'(ex(8'd0, 8'd1, 2'd2, 4'd0, 32'h0000_000A)));

        // Leaf, signed MIN, and the entry's op winning over a later one.
        send(mk(3'd0, 8'd3, 8'd3, 2'd1, 4'd1, 32'd9), 0);
        chk("t3_leaf_max", 76'(packetOut), 76'(ex(8'd3, 8'd3, 2'd1, 4'd1, 32'd9)));
        send(mk(3'd2, 8'd4, 8'd4, 2'd0, 4'd2, 32'hFFFF_FFFD), 0);
        send(mk(3'd2, 8'd4, 8'd4, 2'd0, 4'd2, 32'd4), 0);
        chk("t3_min", 76'(packetOut), 76'(ex(8'd4, 8'd4, 2'd0, 4'd2, 32'hFFFF_FFFD)));
        send(mk(3'd2, 8'd5, 8'd5, 2'd0, 4'd3, 32'h0000_F0F0), 0);
        send(mk(3'd2, 8'd5, 8'd5, 2'd0, 4'd4, 32'h0000_FF00), 0);
        chk("t3_op_wins", 76'(packetOut), 76'(ex(8'd5, 8'd5, 2'd0, 4'd3, 32'h0000_F000)));

        // Fill the table, then a fifth key must wait for a slot.
        for (int c = 0; c < 4; c++) send(mk(3'd2, 8'(c), 8'd7, 2'd0, 4'd0, 32'(10 + c)), 0);
        f = mk(3'd1, 8'd9, 8'd7, 2'd0, 4'd0, 32'h99);
        packetIn = f;
        @(negedge clk);
        chk("t4_full_stall", 76'(in_ready), 76'(0));
        @(posedge clk);
        #1;
        send(mk(3'd2, 8'd0, 8'd7, 2'd0, 4'd0, 32'd1), 0);
        chk("t4_first", 76'(packetOut), 76'(ex(8'd0, 8'd7, 2'd0, 4'd0, 32'd11)));
        packetIn = f;
        @(negedge clk);
        chk("t4_slot_free", 76'(in_ready), 76'(1));
        @(posedge clk);
        #1;
        send(f, 0);
        chk("t4_fifth", 76'(packetOut), 76'(ex(8'd9, 8'd7, 2'd0, 4'd0, 32'h99)));
        for (int c = 1; c < 4; c++) begin
            send(mk(3'd2, 8'(c), 8'd7, 2'd0, 4'd0, 32'(c)), 0);
            chk("t4_rest", 76'(packetOut), 76'(ex(8'(c), 8'd7, 2'd0, 4'd0, 32'(10 + 2 * c))));
        end

        // Backpressure with two finished entries queued behind the output.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(mk(3'd0, 8'd20, 8'd1, 2'd0, 4'd0, 32'h111), 0);
        chk("t5_p", 76'(packetOut), 76'(ex(8'd20, 8'd1, 2'd0, 4'd0, 32'h111)));
        send(mk(3'd0, 8'd21, 8'd1, 2'd0, 4'd0, 32'h222), 0);
        send(mk(3'd0, 8'd22, 8'd1, 2'd0, 4'd0, 32'h333), 0);
        packetIn = mk(3'd0, 8'd21, 8'd1, 2'd0, 4'd0, 32'h444);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold", 76'(packetOut), 76'(ex(8'd20, 8'd1, 2'd0, 4'd0, 32'h111)));
            chk("t5_done_stall", 76'(in_ready), 76'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        packetIn  = '0;
        @(posedge clk);
        #1 chk("t5_drain0", 76'(packetOut), 76'(ex(8'd21, 8'd1, 2'd0, 4'd0, 32'h222)));
        @(posedge clk);
        #1 chk("t5_drain1", 76'(packetOut), 76'(ex(8'd22, 8'd1, 2'd0, 4'd0, 32'h333)));
        send(mk(3'd0, 8'd21, 8'd1, 2'd0, 4'd0, 32'h444), 0);
        chk("t5_reuse", 76'(packetOut), 76'(ex(8'd21, 8'd1, 2'd0, 4'd0, 32'h444)));

        // Unknown op code folds as SUM.
        send(mk(3'd2, 8'd30, 8'd3, 2'd0, 4'hF, 32'd1), 0);
        send(mk(3'd2, 8'd30, 8'd3, 2'd0, 4'hF, 32'd2), 0);
        chk("t6_unknown_op", 76'(packetOut), 76'(ex(8'd30, 8'd3, 2'd0, 4'hF, 32'd3)));
        @(posedge clk);
        #1;

        // Randomised interleaved batches against the scoreboard.
        mon_en = 1'b1;
        for (int b = 0; b < 12; b++) begin
            order.delete();
            for (int k = 0; k < 4; k++) begin
                ch[k]   = 3'($urandom_range(0, 3));
                need[k] = (ch[k] <= 3'd1) ? 1 : int'(ch[k]);
                cnt[k]  = 0;
                rop[k]  = 4'($urandom_range(0, 7));
                ralg[k] = 2'($urandom);
                rctx[k] = {6'($urandom), 2'(k)};
                for (int j = 0; j < need[k]; j++) order.push_back(k);
            end
            for (int j = order.size() - 1; j > 0; j--) begin
                int r, t;
                r        = $urandom_range(0, j);
                t        = order[j];
                order[j] = order[r];
                order[r] = t;
            end
            for (int j = 0; j < order.size(); j++) begin
                int k;
                k       = order[j];
                pl      = $urandom;
                racc[k] = (cnt[k] == 0) ? pl : fold(rop[k], racc[k], pl);
                op_send = (cnt[k] == 0) ? rop[k] : 4'($urandom);
                send(mk(ch[k], rctx[k], 8'(b + 100), ralg[k], op_send, pl), 1);
                cnt[k]++;
                if (cnt[k] == need[k])
                    sb.push_back('{rctx[k], 8'(b + 100), ralg[k], rop[k], racc[k]});
            end
        end
        for (int i = 0; i < 300 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rand_all_drained", 76'(sb.size()), 76'(0));
        chk("rand_out_idle", 76'(packetOut[72]), 76'(0));
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
